// File: rtl/if_id_stage_if.sv
// Bundle of the IF/ID stage's control, fetch bus and pipeline-register signals.
// The master modport is the stage itself; the slave modport is everything around it
// (hazard unit, branch resolution, instruction memory, ID stage).
`timescale 1ns/1ps
interface if_id_stage_if;
    logic        start_i;
    logic        PCWrite_i;
    logic        IF_ID_Write_i;
    logic        Flush_i;
    logic        Branch_i;
    logic [31:0] BranchAddr_i;
    logic [31:0] InstrAddr_o;
    logic [31:0] Instr_i;
    logic [31:0] IF_ID_PC_o;
    logic [31:0] IF_ID_Instr_o;
    logic        IF_ID_Valid_o;
    logic [15:0] StallCnt_o;
    logic [15:0] FlushCnt_o;

    modport master (
        input  start_i, PCWrite_i, IF_ID_Write_i, Flush_i, Branch_i, BranchAddr_i, Instr_i,
        output InstrAddr_o, IF_ID_PC_o, IF_ID_Instr_o, IF_ID_Valid_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        output start_i, PCWrite_i, IF_ID_Write_i, Flush_i, Branch_i, BranchAddr_i, Instr_i,
        input  InstrAddr_o, IF_ID_PC_o, IF_ID_Instr_o, IF_ID_Valid_o, StallCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, presents it to instruction memory, latches the fetched word into
// IF/ID, and keeps saturating counts of stall and flush cycles.
`timescale 1ns/1ps
module if_id_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic           clk_i,
    input  logic           rst_i,
    if_id_stage_if.master  bus
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic pc_advance;
    logic stall_event;
    logic flush_event;

    // Event decode: a branch redirect is never swallowed by a load-use stall.
    always_comb begin
        pc_advance  = bus.start_i && (bus.PCWrite_i || bus.Branch_i);
        stall_event = bus.start_i && !bus.PCWrite_i && !bus.Branch_i;
        flush_event = bus.start_i && bus.Flush_i;
    end

    // Next PC: word-aligned branch target, otherwise sequential (wraps mod 2^32).
    always_comb begin
        pc_d = pc_q;
        if (pc_advance) begin
            if (bus.Branch_i) begin
                pc_d = bus.BranchAddr_i & 32'hFFFF_FFFC;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // IF/ID register: bubble when idle or flushed, hold on hazard, else capture fetch.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (!bus.start_i || bus.Flush_i) begin
            id_pc_d    = pc_q;
            id_instr_d = BUBBLE_INSTR;
            id_valid_d = 1'b0;
        end else if (bus.IF_ID_Write_i) begin
            id_pc_d    = pc_q;
            id_instr_d = bus.Instr_i;
            id_valid_d = 1'b1;
        end
    end

    // Saturating event counters; they stop at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_event && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_instr_q  <= BUBBLE_INSTR;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.InstrAddr_o   = pc_q;
    assign bus.IF_ID_PC_o    = id_pc_q;
    assign bus.IF_ID_Instr_o = id_instr_q;
    assign bus.IF_ID_Valid_o = id_valid_q;
    assign bus.StallCnt_o    = stall_cnt_q;
    assign bus.FlushCnt_o    = flush_cnt_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: IF_ID_Stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter BUBBLE_INSTR, default 32'h00000013 (addi x0,x0,0), meaning the instruction word inserted on flush or idle.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  run enable; low = fetch frozen.
REQ-006 SHALL have port PCWrite_i  input  1  PC update enable from hazard detection (0 = load-use stall).
REQ-007 SHALL have port IF_ID_Write_i  input  1  IF/ID latch enable from hazard detection.
REQ-008 SHALL have port Flush_i  input  1  discard IF/ID contents (taken branch resolved in ID).
REQ-009 SHALL have port Branch_i  input  1  redirect PC to BranchAddr_i.
REQ-010 SHALL have port BranchAddr_i  input  32  branch target.
REQ-011 SHALL have port InstrAddr_o  output  32  current PC to instruction memory.
REQ-012 SHALL have port Instr_i  input  32  instruction word, combinational read of InstrAddr_o.
REQ-013 SHALL have ports IF_ID_PC_o (output, 32), IF_ID_Instr_o (output, 32), and IF_ID_Valid_o (output, 1), carrying the registered ID-stage PC, instruction, and valid flag.
REQ-014 SHALL have ports StallCnt_o (output, 16) and FlushCnt_o (output, 16), carrying saturating stall-cycle and flush-cycle counts.

Function
REQ-015 SHALL drive InstrAddr_o directly from the PC register (no combinational path from inputs).
REQ-016 PC SHALL update only when start_i=1 and (PCWrite_i=1 or Branch_i=1).
REQ-017 PC next value SHALL be {BranchAddr_i[31:2],2'b00} when Branch_i=1, else PC+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-018 Branch_i=1 SHALL take priority over PCWrite_i=0 (redirect is never lost to a stall).
REQ-019 IF/ID latch priority per edge SHALL be: (a) start_i=0 or Flush_i=1 -> Instr<=BUBBLE_INSTR, Valid<=0, PC<=current PC; (b) else IF_ID_Write_i=0 -> hold all three; (c) else Instr<=Instr_i, PC<=InstrAddr_o, Valid<=1.
REQ-020 Flush_i=1 with IF_ID_Write_i=0 in the same cycle SHALL flush (flush wins).
REQ-021 Fetch latency SHALL be one cycle: the word read at InstrAddr_o=A in cycle n appears on IF_ID_Instr_o with IF_ID_PC_o=A in cycle n+1.
REQ-022 During a stall (PCWrite_i=0, IF_ID_Write_i=0, no Branch/Flush), InstrAddr_o and all IF_ID outputs SHALL hold unchanged every cycle the stall persists.
REQ-023 StallCnt_o SHALL increment by 1 each cycle with start_i=1, PCWrite_i=0, Branch_i=0; saturate at 16'hFFFF.
REQ-024 FlushCnt_o SHALL increment by 1 each cycle with start_i=1, Flush_i=1; saturate at 16'hFFFF.
REQ-025 Counters SHALL never wrap and SHALL not change while start_i=0.
REQ-026 start_i falling mid-run SHALL freeze PC and bubble IF/ID on the next edge; rising again SHALL resume fetch from the frozen PC.

Reset
REQ-027 On rst_i=0, asynchronously and without waiting for clk_i: PC=RESET_PC, IF_ID_Instr_o=BUBBLE_INSTR, IF_ID_PC_o=0, IF_ID_Valid_o=0, StallCnt_o=0, FlushCnt_o=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override all other inputs; the first edge after rst_i=1 with start_i=1 fetches from RESET_PC.

Verification
REQ-029 Sequential fetch: reset, start_i=1, PCWrite_i=IF_ID_Write_i=1, Instr_i=PC^32'hA5A5A5A5 -> InstrAddr_o 0,4,8,...; IF_ID_Instr_o equals the prior cycle's word; Valid=1 from cycle 2.
REQ-030 Load-use stall: at PC=8 drop PCWrite_i and IF_ID_Write_i for 2 cycles -> InstrAddr_o stays 8, IF_ID_PC_o stays 4, StallCnt_o=2, then fetch resumes at 12.
REQ-031 Branch+flush: Branch_i=1, Flush_i=1, BranchAddr_i=32'h00000103, with PCWrite_i=0 in the same cycle -> next InstrAddr_o=32'h00000100, IF_ID_Instr_o=32'h00000013, Valid=0, FlushCnt_o=1, StallCnt_o unchanged.
REQ-032 Wrap and saturation: RESET_PC=32'hFFFFFFF8 -> InstrAddr_o FFFFFFF8, FFFFFFFC, 00000000; with PCWrite_i held 0 for 65540 cycles -> StallCnt_o=16'hFFFF.
REQ-033 Async reset: rst_i pulled low between clock edges during a stall -> all outputs reach reset values immediately; after release, fetch restarts at RESET_PC.
REQ-034 start_i toggle: start_i=0 at PC=16 for 3 cycles -> PC held at 16, Valid=0, counters frozen; start_i=1 -> IF_ID_PC_o=16 on the next cycle.
